// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus datapath and its sequencer.
package datapath_pkg;

  localparam int unsigned INSTR_W = 32;

  // Instruction field bit positions
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 28;
  localparam int unsigned RD_MSB    = 27;
  localparam int unsigned RD_LSB    = 23;
  localparam int unsigned RS1_MSB   = 22;
  localparam int unsigned RS1_LSB   = 18;
  localparam int unsigned RS2_MSB   = 17;
  localparam int unsigned RS2_LSB   = 13;
  localparam int unsigned IMM18_MSB = 17;
  localparam int unsigned IMM23_MSB = 22;
  localparam int unsigned IMM18_W   = 18;
  localparam int unsigned IMM23_W   = 23;

  // ALU function select, shared with the datapath ALU
  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADDI = 4'd3,
    OP_SUBI = 4'd4,
    OP_LI   = 4'd5,
    OP_MOV  = 4'd6
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPA  = 2'd1,
    S_OPB  = 2'd2,
    S_WB   = 2'd3
  } seq_state_e;

  // Sign-extend the low 'width' bits of val to 64 bits; callers truncate.
  function automatic logic [63:0] sign_ext(input logic [31:0] val,
                                           input int unsigned width);
    logic [63:0] mask;
    logic [63:0] ext;
    mask = (64'd1 << width) - 64'd1;
    ext  = {32'd0, val} & mask;
    if (((val >> (width - 1)) & 32'd1) != 32'd0) begin
      ext = ext | ~mask;
    end
    return ext;
  endfunction

endpackage

// File: rtl/datapath_sequencer_instr_decode.sv
// Combinational decode of an instruction word into fields, immediates and op class.
module instr_decode
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic [INSTR_W-1:0]   instr,
  output logic [REG_IDX_W-1:0] rd_c,
  output logic [REG_IDX_W-1:0] rs1_c,
  output logic [REG_IDX_W-1:0] rs2_c,
  output logic [DATA_W-1:0]    imm_opb_c,
  output logic [DATA_W-1:0]    imm_li_c,
  output logic                 is_alu_c,
  output logic                 is_imm_c,
  output logic                 is_li_c,
  output logic                 is_nop_c,
  output logic                 is_illegal_c,
  output logic [2:0]           alu_sel_c
);

  logic [3:0] op;

  assign op    = instr[OP_MSB:OP_LSB];
  assign rd_c  = REG_IDX_W'(instr[RD_MSB:RD_LSB]);
  assign rs1_c = REG_IDX_W'(instr[RS1_MSB:RS1_LSB]);
  assign rs2_c = REG_IDX_W'(instr[RS2_MSB:RS2_LSB]);
  assign imm_li_c = DATA_W'(sign_ext(32'(instr[IMM23_MSB:0]), IMM23_W));

  // Operand-B immediate; MOV runs as ADDI with a zero immediate
  assign imm_opb_c = (op == OP_MOV) ? '0
                   : DATA_W'(sign_ext(32'(instr[IMM18_MSB:0]), IMM18_W));

  // Op class and ALU function from the opcode
  always_comb begin
    is_alu_c     = 1'b0;
    is_imm_c     = 1'b0;
    is_li_c      = 1'b0;
    is_nop_c     = 1'b0;
    is_illegal_c = 1'b0;
    alu_sel_c    = ALU_ZERO;
    case (op)
      OP_NOP:  is_nop_c = 1'b1;
      OP_ADD:  begin is_alu_c = 1'b1; alu_sel_c = ALU_ADD; end
      OP_SUB:  begin is_alu_c = 1'b1; alu_sel_c = ALU_SUB; end
      OP_ADDI: begin is_alu_c = 1'b1; is_imm_c = 1'b1; alu_sel_c = ALU_ADD; end
      OP_SUBI: begin is_alu_c = 1'b1; is_imm_c = 1'b1; alu_sel_c = ALU_SUB; end
      OP_LI:   is_li_c = 1'b1;
      OP_MOV:  begin is_alu_c = 1'b1; is_imm_c = 1'b1; alu_sel_c = ALU_ADD; end
      default: is_illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer expanding instructions into single-bus datapath transfers.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic [2:0]           alu_function_sel,
  output logic                 alu_store_1,
  output logic                 alu_store_2,
  output logic                 alu_broadcast,
  output logic [REG_IDX_W-1:0] register_index,
  output logic                 register_read_enable,
  output logic                 register_write_enable,
  output logic [DATA_W-1:0]    imm,
  output logic                 imm_EN,
  output logic                 done,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired_count
);

  seq_state_e state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic hs;

  logic                 ready_q, ready_d;
  logic [2:0]           sel_q, sel_d;
  logic                 st1_q, st1_d;
  logic                 st2_q, st2_d;
  logic                 bc_q, bc_d;
  logic [REG_IDX_W-1:0] idx_q, idx_d;
  logic                 rre_q, rre_d;
  logic                 rwe_q, rwe_d;
  logic [DATA_W-1:0]    imm_q, imm_d;
  logic                 imm_en_q, imm_en_d;
  logic                 done_q, done_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [REG_IDX_W-1:0] rd_c, rs1_c, rs2_c;
  logic [DATA_W-1:0]    imm_opb_c, imm_li_c;
  logic                 is_alu_c, is_imm_c, is_li_c, is_nop_c, is_illegal_c;
  logic [2:0]           alu_sel_c;

  assign hs      = instr_valid && ready_q;
  assign instr_d = hs ? instr : instr_q;

  // Decode the instruction that will be held next cycle
  instr_decode #(
    .DATA_W    (DATA_W),
    .REG_IDX_W (REG_IDX_W)
  ) u_decode (
    .instr        (instr_d),
    .rd_c         (rd_c),
    .rs1_c        (rs1_c),
    .rs2_c        (rs2_c),
    .imm_opb_c    (imm_opb_c),
    .imm_li_c     (imm_li_c),
    .is_alu_c     (is_alu_c),
    .is_imm_c     (is_imm_c),
    .is_li_c      (is_li_c),
    .is_nop_c     (is_nop_c),
    .is_illegal_c (is_illegal_c),
    .alu_sel_c    (alu_sel_c)
  );

  // State and latched instruction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (is_alu_c)     state_d = S_OPA;
          else if (is_li_c) state_d = S_WB;
          else              state_d = S_IDLE;
        end
      end
      S_OPA:   state_d = S_OPB;
      S_OPB:   state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs track the state register
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    sel_d     = ALU_ZERO;
    st1_d     = 1'b0;
    st2_d     = 1'b0;
    bc_d      = 1'b0;
    idx_d     = '0;
    rre_d     = 1'b0;
    rwe_d     = 1'b0;
    imm_d     = '0;
    imm_en_d  = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    if (state_q == S_IDLE && hs) begin
      done_d    = is_nop_c;
      illegal_d = is_illegal_c;
    end
    case (state_d)
      S_OPA: begin
        sel_d = alu_sel_c;
        idx_d = rs1_c;
        rre_d = 1'b1;
        st1_d = 1'b1;
      end
      S_OPB: begin
        sel_d = alu_sel_c;
        st2_d = 1'b1;
        if (is_imm_c) begin
          imm_d    = imm_opb_c;
          imm_en_d = 1'b1;
        end else begin
          idx_d = rs2_c;
          rre_d = 1'b1;
        end
      end
      S_WB: begin
        idx_d  = rd_c;
        rwe_d  = 1'b1;
        done_d = 1'b1;
        if (is_li_c) begin
          imm_d    = imm_li_c;
          imm_en_d = 1'b1;
        end else begin
          sel_d = alu_sel_c;
          bc_d  = 1'b1;
        end
      end
      default: ;
    endcase
    cnt_d = cnt_q + CNT_W'(done_d);
  end

  // Output and retired-count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      sel_q     <= ALU_ZERO;
      st1_q     <= 1'b0;
      st2_q     <= 1'b0;
      bc_q      <= 1'b0;
      idx_q     <= '0;
      rre_q     <= 1'b0;
      rwe_q     <= 1'b0;
      imm_q     <= '0;
      imm_en_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ready_q   <= ready_d;
      sel_q     <= sel_d;
      st1_q     <= st1_d;
      st2_q     <= st2_d;
      bc_q      <= bc_d;
      idx_q     <= idx_d;
      rre_q     <= rre_d;
      rwe_q     <= rwe_d;
      imm_q     <= imm_d;
      imm_en_q  <= imm_en_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign instr_ready           = ready_q;
  assign alu_function_sel      = sel_q;
  assign alu_store_1           = st1_q;
  assign alu_store_2           = st2_q;
  assign alu_broadcast         = bc_q;
  assign register_index        = idx_q;
  assign register_read_enable  = rre_q;
  assign register_write_enable = rwe_q;
  assign imm                   = imm_q;
  assign imm_EN                = imm_en_q;
  assign done                  = done_q;
  assign illegal               = illegal_q;
  assign retired_count         = cnt_q;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle control FSM that drives the control inputs of the single-bus register/ALU datapath.
- Accepts one 32-bit instruction per valid/ready handshake and expands it into a sequence of bus transfers: register read, immediate drive, ALU operand latch, ALU broadcast, register write.
- Guarantees exactly one bus driver per cycle.
- Reports completion, illegal opcodes and a retired-instruction count.

Parameters:
- DATA_W, 32, bus/immediate width
- REG_IDX_W, 5, register index width
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr  in  32  instruction word, sampled on handshake
- instr_valid  in  1  instruction presented
- instr_ready  out  1  sequencer can accept
- alu_function_sel  out  3  0=zero, 1=add, 2=sub
- alu_store_1  out  1  latch bus into ALU operand 1
- alu_store_2  out  1  latch bus into ALU operand 2
- alu_broadcast  out  1  ALU result drives bus
- register_index  out  REG_IDX_W  register selected for read/write
- register_read_enable  out  1  selected register drives bus
- register_write_enable  out  1  bus written to selected register
- imm  out  DATA_W  immediate value
- imm_EN  out  1  imm drives bus
- done  out  1  one-cycle pulse on the instruction's final cycle
- illegal  out  1  one-cycle pulse when an illegal opcode is accepted
- retired_count  out  CNT_W  count of completed legal instructions

Behaviour:
- Instruction format:
  - op = instr[31:28], rd = [27:23], rs1 = [22:18], rs2 = [17:13].
  - imm18 = [17:0], sign-extended to DATA_W.
  - imm23 = [22:0], sign-extended to DATA_W.
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rs1+rs2
  - 2 SUB rd=rs1-rs2
  - 3 ADDI rd=rs1+imm18
  - 4 SUBI rd=rs1-imm18
  - 5 LI rd=imm23
  - 6 MOV rd=rs1, executed as ADDI with imm 0
  - 7-15 illegal
- States: IDLE, OPA, OPB, WB.
- instr_ready = 1 only in IDLE and not in reset. Handshake occurs when instr_valid && instr_ready; instr is latched into an internal register on that edge.
- Transitions from IDLE on handshake:
  - ADD/SUB/ADDI/SUBI/MOV -> OPA.
  - LI -> WB.
  - NOP -> IDLE, with done pulsed in the cycle after the handshake.
  - Illegal -> IDLE, with illegal pulsed in the cycle after the handshake; no done, no count.
- Transitions from datapath states: OPA -> OPB -> WB -> IDLE, unconditionally.
- Per-state outputs (Moore; decoded from state and latched instruction only):
  - OPA: register_index=rs1, register_read_enable=1, alu_store_1=1.
  - OPB, reg-reg ops: register_index=rs2, register_read_enable=1, alu_store_2=1.
  - OPB, imm ops: imm=imm18 (0 for MOV), imm_EN=1, alu_store_2=1.
  - WB, ALU ops: alu_broadcast=1, register_index=rd, register_write_enable=1, done=1.
  - WB, LI: imm=imm23, imm_EN=1, register_index=rd, register_write_enable=1, done=1.
- alu_function_sel = 1 for ADD/ADDI/MOV, 2 for SUB/SUBI; held in OPA..WB; 0 in IDLE and for LI.
- Bus exclusivity invariant: register_read_enable + alu_broadcast + imm_EN <= 1 in every cycle.
- Latency: ALU ops take 3 cycles after the handshake cycle and LI takes 1. The next handshake is possible in the cycle after WB.
- retired_count increments on every done pulse, including NOP, and wraps modulo 2^CNT_W.
- Reset (any time, including mid-instruction):
  - State -> IDLE; latched instr, retired_count and all outputs -> 0.
  - instr_ready deasserts while reset is high.
  - An in-flight instruction is discarded with no write.
- Unused output fields: imm=0 and register_index=0 whenever not specified above.

Decomposition:
- Package datapath_pkg holds:
  - opcode enum op_e.
  - state enum seq_state_e.
  - ALU select constants ALU_ZERO/ALU_ADD/ALU_SUB.
  - Instruction field bit positions.
  - Function sign_ext(). The datapath must later use the same ALU constants.
- One sub-module, instr_decode: combinational mapping of the latched instr to fields, immediates, op class and ALU select.

Test Plan:
- Reset released; instr_valid=0 -> all outputs 0, instr_ready=1, retired_count=0.
- LI r3,-5 (op5, imm23=0x7FFFFB) -> next cycle WB: imm=0xFFFFFFFB, imm_EN=1, register_index=3, register_write_enable=1, done=1; retired_count=1.
- ADD r4,r1,r2 with r1=7, r2=9 -> OPA idx1 read+store_1, OPB idx2 read+store_2, WB broadcast write idx4; r4=16 after 4 cycles; instr_ready low for 3 cycles.
- SUBI r5,r5,1 with r5=0 -> r5=0xFFFFFFFF; then MOV r6,r5 -> r6=0xFFFFFFFF; a bus-exclusivity assertion checked every cycle.
- Opcode 9 -> illegal pulses 1 cycle, done=0, retired_count unchanged, no write enable seen.
- Reset asserted in OPB of ADD -> outputs 0 the same cycle, no register write; after release the next LI completes normally. Separately, retired_count preloaded to 0xFFFF then one NOP -> 0x0000.
